// File: rtl/mem_access_stage_pkg.sv
// ============================================================================
// Module      : mem_access_stage_pkg
// Description : Shared widths, beat count and FSM state type for the memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_stage_pkg;

    localparam int DEF_DATA_W = 192;
    localparam int DEF_BUS_W  = 64;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_RD_W   = 4;
    localparam int BEATS_MAX  = DEF_DATA_W / DEF_BUS_W;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Counter width that stays at least one bit when only one beat exists.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_if.sv
// ============================================================================
// Module      : mem_access_stage_if
// Description : Narrow valid/ready data-memory bus between the stage and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_stage_if
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BUS_W  = DEF_BUS_W
);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BUS_W-1:0]  mem_wdata;
    logic              mem_ready;
    logic [BUS_W-1:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module      : mem_access_stage
// Description : Scalar/vector load-store stage with beat sequencing and stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BUS_W  = DEF_BUS_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_W   = DEF_RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemToReg_in,
    input  logic              MemWrite_in,
    input  logic              VectorOp_in,
    input  logic              RegSWrite_in,
    input  logic              RegVWrite_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] mux1_in,
    input  logic [RD_W-1:0]   RD_in,
    output logic              stall_out,
    mem_access_stage_if.master mem_bus,
    output logic              MemToReg_out,
    output logic              RegSWrite_out,
    output logic              RegVWrite_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic [RD_W-1:0]   RD_out
);

    localparam int                NBEATS     = DATA_W / BUS_W;
    localparam int                CNT_W      = cnt_width(NBEATS);
    localparam logic [CNT_W-1:0]  LAST_VEC   = CNT_W'(NBEATS - 1);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BUS_W / 8);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              op_mtr_q, op_mw_q, op_vec_q, op_rsw_q, op_rvw_q;
    logic [DATA_W-1:0] op_alu_q, op_sdata_q, buf_q;
    logic [RD_W-1:0]   op_rd_q;

    logic              mtr_out_q, rsw_out_q, rvw_out_q;
    logic [DATA_W-1:0] alu_out_q, rdata_out_q;
    logic [RD_W-1:0]   rd_out_q;

    logic              w_is_mem;
    logic [CNT_W-1:0]  w_last_cnt;
    logic              w_last_beat;
    logic [DATA_W-1:0] w_merged;

    assign w_is_mem    = MemToReg_in | MemWrite_in;
    assign w_last_cnt  = op_vec_q ? LAST_VEC : '0;
    assign w_last_beat = (state_q == ACCESS) && (cnt_q == w_last_cnt) && mem_bus.mem_ready;
    assign stall_out   = ((state_q == IDLE) && w_is_mem) || ((state_q == ACCESS) && !w_last_beat);

    assign mem_bus.mem_req   = (state_q == ACCESS);
    assign mem_bus.mem_we    = (state_q == ACCESS) && op_mw_q;
    assign mem_bus.mem_addr  = op_alu_q[ADDR_W-1:0] + ADDR_W'(cnt_q) * BEAT_BYTES;
    assign mem_bus.mem_wdata = op_sdata_q[cnt_q*BUS_W +: BUS_W];

    // Final beat is folded in here so writeback happens on the completing edge.
    always_comb begin
        w_merged = buf_q;
        w_merged[cnt_q*BUS_W +: BUS_W] = mem_bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_mtr_q    <= 1'b0;
            op_mw_q     <= 1'b0;
            op_vec_q    <= 1'b0;
            op_rsw_q    <= 1'b0;
            op_rvw_q    <= 1'b0;
            op_alu_q    <= '0;
            op_sdata_q  <= '0;
            op_rd_q     <= '0;
            buf_q       <= '0;
            mtr_out_q   <= 1'b0;
            rsw_out_q   <= 1'b0;
            rvw_out_q   <= 1'b0;
            alu_out_q   <= '0;
            rdata_out_q <= '0;
            rd_out_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_is_mem) begin
                        op_mtr_q   <= MemToReg_in;
                        op_mw_q    <= MemWrite_in;
                        op_vec_q   <= VectorOp_in;
                        op_rsw_q   <= RegSWrite_in;
                        op_rvw_q   <= RegVWrite_in;
                        op_alu_q   <= alu_in;
                        op_sdata_q <= mux1_in;
                        op_rd_q    <= RD_in;
                        buf_q      <= '0;
                        cnt_q      <= '0;
                        mtr_out_q  <= 1'b0;
                        rsw_out_q  <= 1'b0;
                        rvw_out_q  <= 1'b0;
                        state_q    <= ACCESS;
                    end else begin
                        mtr_out_q   <= MemToReg_in;
                        rsw_out_q   <= RegSWrite_in;
                        rvw_out_q   <= RegVWrite_in;
                        alu_out_q   <= alu_in;
                        rdata_out_q <= '0;
                        rd_out_q    <= RD_in;
                    end
                end
                ACCESS: begin
                    if (mem_bus.mem_ready) begin
                        if (!op_mw_q) begin
                            buf_q[cnt_q*BUS_W +: BUS_W] <= mem_bus.mem_rdata;
                        end
                        if (w_last_beat) begin
                            mtr_out_q   <= op_mtr_q;
                            rsw_out_q   <= op_rsw_q;
                            rvw_out_q   <= op_rvw_q;
                            alu_out_q   <= op_alu_q;
                            rdata_out_q <= op_mw_q ? '0 : w_merged;
                            rd_out_q    <= op_rd_q;
                            cnt_q       <= '0;
                            state_q     <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MemToReg_out  = mtr_out_q;
    assign RegSWrite_out = rsw_out_q;
    assign RegVWrite_out = rvw_out_q;
    assign alu_out       = alu_out_q;
    assign rdata_out     = rdata_out_q;
    assign RD_out        = rd_out_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Scoreboard bench for the memory stage with a delaying memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int DATA_W = DEF_DATA_W;
    localparam int BUS_W  = DEF_BUS_W;
    localparam int ADDR_W = DEF_ADDR_W;
    localparam int RD_W   = DEF_RD_W;
    localparam int NB     = DATA_W / BUS_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              MemToReg_in, MemWrite_in, VectorOp_in, RegSWrite_in, RegVWrite_in;
    logic [DATA_W-1:0] alu_in, mux1_in;
    logic [RD_W-1:0]   RD_in;
    logic              stall_out;
    logic              MemToReg_out, RegSWrite_out, RegVWrite_out;
    logic [DATA_W-1:0] alu_out, rdata_out;
    logic [RD_W-1:0]   RD_out;

    always #5 clk = ~clk;

    mem_access_stage_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W)) bus ();

    mem_access_stage #(
        .DATA_W(DATA_W), .BUS_W(BUS_W), .ADDR_W(ADDR_W), .RD_W(RD_W)
    ) dut (
        .clk(clk), .rst(rst),
        .MemToReg_in(MemToReg_in), .MemWrite_in(MemWrite_in), .VectorOp_in(VectorOp_in),
        .RegSWrite_in(RegSWrite_in), .RegVWrite_in(RegVWrite_in),
        .alu_in(alu_in), .mux1_in(mux1_in), .RD_in(RD_in),
        .stall_out(stall_out), .mem_bus(bus),
        .MemToReg_out(MemToReg_out), .RegSWrite_out(RegSWrite_out), .RegVWrite_out(RegVWrite_out),
        .alu_out(alu_out), .rdata_out(rdata_out), .RD_out(RD_out)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BUS_W-1:0]  wdata;
    } beat_t;

    typedef struct {
        logic              mtr, rsw, rvw;
        logic [DATA_W-1:0] alu, rdata;
        logic [RD_W-1:0]   rd;
    } res_t;

    beat_t beat_q[$];
    res_t  res_q[$];
    int    delay_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit drv_valid = 1'b0;
    bit adv = 1'b0;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a ^ 32'hC0DE_F00D, ~a};
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Memory model: per-beat wait states from delay_q, checks hold stability and beat contents.
    bit                have = 1'b0;
    int                rem  = 0;
    logic [ADDR_W-1:0] h_addr;
    logic [BUS_W-1:0]  h_wdata;
    logic              h_we;
    always @(posedge clk) begin
        beat_t b;
        #1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = {$urandom, $urandom};
        if (bus.mem_req) begin
            if (!have) begin
                have    = 1'b1;
                rem     = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                h_addr  = bus.mem_addr;
                h_wdata = bus.mem_wdata;
                h_we    = bus.mem_we;
            end else begin
                check_val("addr_hold", DATA_W'(bus.mem_addr), DATA_W'(h_addr));
                check_val("wdata_hold", DATA_W'(bus.mem_wdata), DATA_W'(h_wdata));
                check_val("we_hold", DATA_W'(bus.mem_we), DATA_W'(h_we));
            end
            if (rem == 0) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_word(bus.mem_addr);
                have = 1'b0;
                if (beat_q.size() == 0) begin
                    check_val("beat_unexpected", DATA_W'(1), DATA_W'(0));
                end else begin
                    b = beat_q.pop_front();
                    check_val("beat_addr", DATA_W'(bus.mem_addr), DATA_W'(b.addr));
                    check_val("beat_we", DATA_W'(bus.mem_we), DATA_W'(b.we));
                    if (b.we) check_val("beat_wdata", DATA_W'(bus.mem_wdata), DATA_W'(b.wdata));
                end
            end else begin
                rem--;
            end
        end else begin
            have = 1'b0;
        end
    end

    // Writeback monitor: an edge with stall low retires the scored op.
    always @(negedge clk) adv = drv_valid && !stall_out && !rst;
    always @(posedge clk) begin
        res_t r;
        if (adv) begin
            #2;
            if (res_q.size() == 0) begin
                check_val("result_unexpected", DATA_W'(1), DATA_W'(0));
            end else begin
                r = res_q.pop_front();
                check_val("wb_memtoreg", DATA_W'(MemToReg_out), DATA_W'(r.mtr));
                check_val("wb_regswrite", DATA_W'(RegSWrite_out), DATA_W'(r.rsw));
                check_val("wb_regvwrite", DATA_W'(RegVWrite_out), DATA_W'(r.rvw));
                check_val("wb_alu", alu_out, r.alu);
                check_val("wb_rdata", rdata_out, r.rdata);
                check_val("wb_rd", DATA_W'(RD_out), DATA_W'(r.rd));
            end
        end
    end

    task automatic drive_in(input logic mtr, mw, vec, rsw, rvw,
                            input logic [DATA_W-1:0] alu, mux, input logic [RD_W-1:0] rd);
        MemToReg_in  = mtr;
        MemWrite_in  = mw;
        VectorOp_in  = vec;
        RegSWrite_in = rsw;
        RegVWrite_in = rvw;
        alu_in       = alu;
        mux1_in      = mux;
        RD_in        = rd;
    endtask

    task automatic run_op(input string name, input logic mtr, mw, vec, rsw, rvw,
                          input logic [DATA_W-1:0] alu, mux, input logic [RD_W-1:0] rd,
                          input int exp_stall, input bit scramble);
        res_t r;
        int   nb;
        int   n;
        logic [ADDR_W-1:0] a;
        nb = vec ? NB : 1;
        r.mtr = mtr; r.rsw = rsw; r.rvw = rvw; r.alu = alu; r.rd = rd; r.rdata = '0;
        if (mtr | mw) begin
            for (int i = 0; i < nb; i++) begin
                a = alu[ADDR_W-1:0] + ADDR_W'(i * (BUS_W / 8));
                beat_q.push_back('{addr: a, we: mw, wdata: mux[i*BUS_W +: BUS_W]});
                if (!mw) r.rdata[i*BUS_W +: BUS_W] = mem_word(a);
            end
        end
        res_q.push_back(r);
        drive_in(mtr, mw, vec, rsw, rvw, alu, mux, rd);
        drv_valid = 1'b1;
        #1;
        n = 0;
        while (stall_out && n < 100) begin
            n++;
            @(posedge clk);
            #1;
            if (scramble) begin
                alu_in  = rand_data();
                mux1_in = rand_data();
            end
            #1;
        end
        check_val({name, "_stall_cycles"}, DATA_W'(n), DATA_W'(exp_stall));
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        drive_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        logic [DATA_W-1:0] mux;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        rst = 1'b1;
        drive_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_memtoreg", DATA_W'(MemToReg_out), '0);
        check_val("rst_regswrite", DATA_W'(RegSWrite_out), '0);
        check_val("rst_regvwrite", DATA_W'(RegVWrite_out), '0);
        check_val("rst_alu", alu_out, '0);
        check_val("rst_rdata", rdata_out, '0);
        check_val("rst_rd", DATA_W'(RD_out), '0);
        check_val("rst_mem_req", DATA_W'(bus.mem_req), '0);
        check_val("rst_stall", DATA_W'(stall_out), '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("nonmem", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, DATA_W'(32'hABCD), '0, 4'd5, 0, 1'b0);
        run_op("vload", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, DATA_W'(32'h100), rand_data(), 4'd3, 3, 1'b0);

        mux = rand_data();
        mux[63:0] = 64'h1122_3344_5566_7788;
        delay_q.push_back(3);
        run_op("sstore", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DATA_W'(32'h40), mux, 4'd1, 4, 1'b1);

        delay_q.push_back(0); delay_q.push_back(2); delay_q.push_back(0);
        run_op("vload_wait", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, DATA_W'(32'h300), '0, 4'd9, 5, 1'b0);

        run_op("sload", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, DATA_W'(32'h80), '0, 4'd2, 1, 1'b0);
        run_op("vstore", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DATA_W'(32'h500), rand_data(), 4'd4, 3, 1'b0);
        run_op("nonmem2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rand_data(), '0, 4'd7, 0, 1'b0);

        // Abort a vector store while its second beat is still waiting.
        mux = rand_data();
        beat_q.push_back('{addr: 32'h200, we: 1'b1, wdata: mux[63:0]});
        delay_q.push_back(0); delay_q.push_back(10);
        drive_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DATA_W'(32'h200), mux, 4'd6);
        #1;
        check_val("abort_accept_stall", DATA_W'(stall_out), DATA_W'(1));
        repeat (2) @(posedge clk);
        #1;
        check_val("abort_req_before", DATA_W'(bus.mem_req), DATA_W'(1));
        rst = 1'b1;
        drive_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #2;
        check_val("abort_mem_req", DATA_W'(bus.mem_req), '0);
        check_val("abort_memtoreg", DATA_W'(MemToReg_out), '0);
        check_val("abort_regswrite", DATA_W'(RegSWrite_out), '0);
        check_val("abort_regvwrite", DATA_W'(RegVWrite_out), '0);
        check_val("abort_alu", alu_out, '0);
        check_val("abort_rdata", rdata_out, '0);
        check_val("abort_rd", DATA_W'(RD_out), '0);
        check_val("abort_stall", DATA_W'(stall_out), '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DATA_W'(32'h1234), '0, 4'hA, 0, 1'b0);
        run_op("wrap", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, DATA_W'(32'hFFFF_FFF8), '0, 4'hC, 3, 1'b0);

        repeat (4) @(posedge clk);
        #3;
        check_val("res_q_empty", DATA_W'(res_q.size()), '0);
        check_val("beat_q_empty", DATA_W'(beat_q.size()), '0);
        check_val("delay_q_empty", DATA_W'(delay_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage sitting directly downstream of the EX/MEM pipeline register; consumes its control bits, ALU result (address or result), store data and destination register.
- Performs scalar (1-beat) and vector (DATA_W/BUS_W-beat) loads and stores over a narrow valid/ready data-memory bus.
- Stalls upstream while busy; drives registered MEM/WB-facing outputs.

Parameters:
- DATA_W, 192, vector/datapath width.
- BUS_W, 64, memory bus width; DATA_W must be an integer multiple.
- ADDR_W, 32, memory address width (taken from alu_in[ADDR_W-1:0]).
- RD_W, 4, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- MemToReg_in, MemWrite_in, VectorOp_in, RegSWrite_in, RegVWrite_in  in  1 each  control from EX/MEM.
- alu_in  in  DATA_W  ALU result; low ADDR_W bits are the address for memory ops.
- mux1_in  in  DATA_W  store data.
- RD_in  in  RD_W  destination register.
- stall_out  out  1  combinational; upstream holds EX/MEM while high.
- mem_req  out  1  bus request, valid in ACCESS only.
- mem_we  out  1  1 = write beat.
- mem_addr  out  ADDR_W  beat address.
- mem_wdata  out  BUS_W  write beat data.
- mem_ready  in  1  beat accepted/completed this cycle.
- mem_rdata  in  BUS_W  read beat data, valid with mem_ready on reads.
- MemToReg_out, RegSWrite_out, RegVWrite_out  out  1 each  registered control to MEM/WB.
- alu_out  out  DATA_W  registered ALU result.
- rdata_out  out  DATA_W  registered load data.
- RD_out  out  RD_W  registered destination.

Behaviour:
- Reset: all outputs and internal registers 0; state IDLE; mem_req 0 from the first edge with rst high.
- is_mem = MemToReg_in | MemWrite_in. beats = VectorOp ? DATA_W/BUS_W : 1.
- IDLE, !is_mem:
  - stall_out 0.
  - Next edge registers all *_in to *_out; rdata_out = 0. Latency 1.
- IDLE, is_mem (accept cycle):
  - stall_out 1.
  - Latch control bits, address, store data and RD into the op register; beat counter = 0; go to ACCESS.
  - Outputs take a bubble at this edge: MemToReg/RegSWrite/RegVWrite = 0; other outputs hold.
- ACCESS:
  - mem_req 1, mem_we = latched MemWrite.
  - mem_addr = base + cnt*(BUS_W/8), wrapping mod 2^ADDR_W. Low address bits are not checked; alignment is the software's responsibility.
  - mem_wdata = store_data[cnt*BUS_W +: BUS_W].
  - Request and address/data held stable until mem_ready.
  - On mem_ready for a read: buffer[cnt*BUS_W +: BUS_W] = mem_rdata; cnt++.
  - Outputs remain bubble while in ACCESS.
- Last beat (cnt == beats-1 && mem_ready):
  - stall_out 0 in that cycle, so upstream advances at the same edge.
  - Return to IDLE.
  - Register latched op to outputs. rdata_out = buffer, with the final beat merged in; scalar loads are zero-extended from BUS_W. For stores, rdata_out = 0 and write enables pass through as latched.
- stall_out = (IDLE & is_mem) | (ACCESS & !(last beat & mem_ready)).
- Minimum memory-op latency: 1 + beats cycles. With mem_ready tied 1, a vector load's outputs are valid after the 4th edge.
- mem_ready outside ACCESS is ignored.
- Input changes during ACCESS are ignored; only the latched op is used.
- Back-to-back memory ops: the second is accepted in the IDLE cycle after completion, never in the same cycle.
- rst during ACCESS: abort immediately, mem_req 0 after the edge, no writeback. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package (e.g., mem_pkg): DATA_W/BUS_W/ADDR_W defaults, BEATS_MAX constant, state enum typedef (IDLE, ACCESS).
- No sub-module; beat counter, address generation and FSM fit in one module.

Test Plan:
- Non-mem op, alu_in=0xABCD, RD_in=5, RegSWrite_in=1 -> next edge alu_out=0xABCD, RD_out=5, RegSWrite_out=1, stall_out never high.
- Vector load, addr 0x100, mem_ready tied 1, rdata beats A/B/C -> mem_addr 0x100/0x108/0x110; rdata_out={C,B,A}; RegVWrite_out=1 after 4 edges; stall_out high for 3 cycles.
- Scalar store, addr 0x40, mux1_in low 64 bits=0x1122334455667788, mem_ready delayed 3 cycles -> single beat; mem_addr/mem_wdata stable all 3 wait cycles; mem_we=1; write enables out 0.
- Vector load with mem_ready low on beat 2 for 2 cycles -> beat 2 address held; total 6 cycles; data correct.
- rst asserted during beat 1 of a vector store -> mem_req 0 next cycle; all outputs 0; next non-mem op processed normally.
- Address wrap: vector load at 0xFFFFFFF8 -> beat addresses 0xFFFFFFF8, 0x0, 0x8.
